// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one NoC output link between NUM_IN valid/ready sources.
// One-entry registered output stage with full throughput and a forwarded-packet counter.
module noc_port_arbiter #(
    parameter int unsigned NUM_IN           = 4,
    parameter int unsigned DATA_PACKET_SIZE = 32,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_IN-1:0]                  in_valid,
    input  logic [NUM_IN*DATA_PACKET_SIZE-1:0] in_data,
    output logic [NUM_IN-1:0]                  in_ready,
    output logic                               out_valid,
    output logic [DATA_PACKET_SIZE-1:0]        out_data,
    input  logic                               out_ready,
    output logic [$clog2(NUM_IN)-1:0]          grant_id,
    output logic [CNT_W-1:0]                   pkt_count
);

    localparam int unsigned IDX_W = $clog2(NUM_IN);

    logic                        valid_q, valid_d;
    logic [DATA_PACKET_SIZE-1:0] data_q, data_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]            last_q, last_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        load_c;
    logic                        drain_c;
    logic                        accept_c;
    logic                        any_valid_c;
    logic [IDX_W-1:0]            winner_c;
    logic [DATA_PACKET_SIZE-1:0] slice_c [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_slice
        assign slice_c[g] = in_data[g*DATA_PACKET_SIZE +: DATA_PACKET_SIZE];
    end

    // First valid source after the last grant, wrapping modulo NUM_IN
    always_comb begin
        int unsigned idx;
        idx         = 0;
        winner_c    = '0;
        any_valid_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            idx = (32'(last_q) + k) % NUM_IN;
            if (!any_valid_c && in_valid[IDX_W'(idx)]) begin
                winner_c    = IDX_W'(idx);
                any_valid_c = 1'b1;
            end
        end
    end

    assign load_c   = !valid_q || out_ready;
    assign drain_c  = valid_q && out_ready;
    assign accept_c = load_c && any_valid_c && !rst;
    assign in_ready = accept_c ? (NUM_IN'(1) << winner_c) : '0;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (accept_c) begin
            valid_d = 1'b1;
            data_d  = slice_c[winner_c];
            grant_d = winner_c;
            last_d  = winner_c;
        end else if (drain_c) begin
            valid_d = 1'b0;
        end
        if (drain_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Reset leaves source 0 with first priority and discards any held packet
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_IN - 1);
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign grant_id  = grant_q;
    assign pkt_count = cnt_q;

endmodule
